// File: rtl/usb_hub_pkg.sv
// Shared definitions for the hub port polling logic: scheduler FSM encoding
// and the helper that sizes port-index fields.
package usb_hub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_REQ    = 2'd2,
        ST_WAIT   = 2'd3
    } poll_state_e;

    // Width of a port index; a single port still needs one bit.
    function automatic int port_idx_width(input int num_ports);
        return (num_ports < 2) ? 1 : $clog2(num_ports);
    endfunction

endpackage

// File: rtl/poll_interval_timer.sv
// Free-running interval counter; tick is high during the last cycle of each
// POLL_INTERVAL-cycle period.
module poll_interval_timer #(
    parameter int POLL_INTERVAL = 100
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CW = (POLL_INTERVAL < 2) ? 1 : $clog2(POLL_INTERVAL);
    localparam logic [CW-1:0] LAST = CW'(POLL_INTERVAL - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/port_poll_scheduler.sv
// Round-based poll scheduler: on each interval tick it walks the enabled
// ports in ascending order, one request/completion (or timeout) at a time.
module port_poll_scheduler
    import usb_hub_pkg::*;
#(
    parameter int NUM_PORTS     = 4,
    parameter int POLL_INTERVAL = 100,
    parameter int POLL_TIMEOUT  = 64
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [NUM_PORTS-1:0]                  port_enable,
    output logic                                  poll_valid,
    output logic [port_idx_width(NUM_PORTS)-1:0]  poll_port,
    input  logic                                  poll_ready,
    input  logic                                  poll_done,
    output logic [NUM_PORTS-1:0]                  timeout_status,
    output logic                                  round_done,
    output logic                                  overrun,
    output logic                                  busy
);

    localparam int PW = port_idx_width(NUM_PORTS);
    localparam int TW = (POLL_TIMEOUT < 2) ? 1 : $clog2(POLL_TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(POLL_TIMEOUT - 1);

    poll_state_e          state_q, state_d;
    logic [NUM_PORTS-1:0] round_mask_q, round_mask_d;
    logic [PW-1:0]        cur_q, cur_d;
    logic [TW-1:0]        to_cnt_q, to_cnt_d;
    logic [NUM_PORTS-1:0] timeout_status_q, timeout_status_d;
    logic                 round_done_q, round_done_d;
    logic                 overrun_q, overrun_d;

    logic                 tick;
    logic [NUM_PORTS-1:0] eff;
    logic                 eff_any;
    logic [PW-1:0]        low_idx;
    logic                 to_expired;

    poll_interval_timer #(
        .POLL_INTERVAL (POLL_INTERVAL)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    // Ports dropped from port_enable mid-round are skipped at their turn.
    assign eff        = round_mask_q & port_enable;
    assign eff_any    = |eff;
    assign to_expired = (to_cnt_q == TO_LAST);

    // Lowest set bit of eff; scanning downward lets the lowest index win.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (eff[i]) begin
                low_idx = PW'(i);
            end
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_d          = state_q;
        round_mask_d     = round_mask_q;
        cur_d            = cur_q;
        to_cnt_d         = to_cnt_q;
        timeout_status_d = timeout_status_q;
        round_done_d     = 1'b0;
        overrun_d        = tick && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    round_mask_d = port_enable;
                    if (|port_enable) begin
                        state_d = ST_SELECT;
                    end
                end
            end

            ST_SELECT: begin
                if (eff_any) begin
                    cur_d                 = low_idx;
                    round_mask_d[low_idx] = 1'b0;
                    state_d               = ST_REQ;
                end else begin
                    round_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end

            ST_REQ: begin
                if (poll_ready) begin
                    to_cnt_d = '0;
                    state_d  = ST_WAIT;
                end
            end

            ST_WAIT: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (poll_done) begin
                    timeout_status_d[cur_q] = 1'b0;
                    state_d                 = ST_SELECT;
                end else if (to_expired) begin
                    timeout_status_d[cur_q] = 1'b1;
                    state_d                 = ST_SELECT;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            round_mask_q     <= '0;
            cur_q            <= '0;
            to_cnt_q         <= '0;
            timeout_status_q <= '0;
            round_done_q     <= 1'b0;
            overrun_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            round_mask_q     <= round_mask_d;
            cur_q            <= cur_d;
            to_cnt_q         <= to_cnt_d;
            timeout_status_q <= timeout_status_d;
            round_done_q     <= round_done_d;
            overrun_q        <= overrun_d;
        end
    end

    assign poll_valid     = (state_q == ST_REQ);
    assign poll_port      = cur_q;
    assign busy           = (state_q != ST_IDLE);
    assign timeout_status = timeout_status_q;
    assign round_done     = round_done_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_port_poll_scheduler.sv
// Bench for port_poll_scheduler: a bench-side poll engine with random
// latencies, checked against round timelines derived from the polling rules.
module tb_port_poll_scheduler;

    localparam int NP   = 4;
    localparam int IVL  = 100;
    localparam int TOUT = 64;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NP-1:0] port_enable = '0;
    logic          poll_valid;
    logic [1:0]    poll_port;
    logic          poll_ready = 1'b0;
    logic          poll_done = 1'b0;
    logic [NP-1:0] timeout_status;
    logic          round_done;
    logic          overrun;
    logic          busy;

    port_poll_scheduler #(
        .NUM_PORTS     (NP),
        .POLL_INTERVAL (IVL),
        .POLL_TIMEOUT  (TOUT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .port_enable    (port_enable),
        .poll_valid     (poll_valid),
        .poll_port      (poll_port),
        .poll_ready     (poll_ready),
        .poll_done      (poll_done),
        .timeout_status (timeout_status),
        .round_done     (round_done),
        .overrun        (overrun),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int ov_cnt   = 0;
    int rd_cnt   = 0;
    int hs_cnt   = 0;

    // Expected per-port timeout flags and per-port engine behaviour for the
    // next round: ka = WAIT cycle carrying poll_done (0 = never), ra = ready delay.
    logic [NP-1:0] exp_ts = '0;
    int ka [NP];
    int ra [NP];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Event counters sampled at the active edge, outside reset.
    always @(posedge clock) begin
        if (!reset) begin
            if (overrun) ov_cnt++;
            if (round_done) rd_cnt++;
            if (poll_valid && poll_ready) hs_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One cycle per call; inputs set after it are sampled at the next edge.
    task automatic step();
        @(negedge clock);
        cyc++;
    endtask

    // Advance to the next tick cycle, checking that nothing starts early and
    // toggling engine inputs that must be ignored while idle.
    task automatic wait_tick(output int t);
        t = cyc + ((IVL - 1 - (cyc % IVL)) + IVL) % IVL;
        while (cyc < t) begin
            check("idle_busy", busy, 1'b0);
            poll_ready = 1'($urandom);
            poll_done  = 1'($urandom);
            step();
        end
        poll_ready = 1'b0;
        poll_done  = 1'b0;
        check("tick_busy", busy, 1'b0);
    endtask

    task automatic run_round(input logic [NP-1:0] en, input int dis_when, input int dis_port);
        int t, s, ov0, rd0, hs0, exp_ov, n_polls;
        logic [NP-1:0] live;
        logic more;
        port_enable = en;
        wait_tick(t);
        ov0 = ov_cnt; rd0 = rd_cnt; hs0 = hs_cnt;
        n_polls = 0;
        step();
        if (en == '0) begin
            for (int i = 0; i < 3; i++) begin
                check("empty_busy", busy, 1'b0);
                step();
            end
            check("empty_round_done", rd_cnt - rd0, 0);
            return;
        end
        check("sel_busy", busy, 1'b1);
        check("sel_valid", poll_valid, 1'b0);
        live = en;
        for (int p = 0; p < NP; p++) begin
            if (!live[p]) continue;
            step();
            check("req_valid", poll_valid, 1'b1);
            check("req_port", poll_port, p);
            for (int j = 0; j < ra[p]; j++) begin
                poll_ready = 1'b0;
                step();
                check("bp_valid", poll_valid, 1'b1);
                check("bp_port", poll_port, p);
            end
            poll_ready = 1'b1;
            step();
            n_polls++;
            for (int w = 1; w <= TOUT; w++) begin
                poll_ready = 1'($urandom);
                if (w == 1) check("wait_valid", poll_valid, 1'b0);
                if (p == dis_when && w == 1 && dis_port >= 0) begin
                    port_enable[dis_port] = 1'b0;
                    live[dis_port] = 1'b0;
                end
                poll_done = (ka[p] == w);
                if (ka[p] == w || w == TOUT) begin
                    check("ts_hold", timeout_status, exp_ts);
                    break;
                end
                step();
            end
            exp_ts[p] = (ka[p] == 0);
            step();
            poll_done  = 1'b0;
            poll_ready = 1'b0;
            check("ts_after_poll", timeout_status, exp_ts);
            check("next_sel_busy", busy, 1'b1);
            check("next_sel_valid", poll_valid, 1'b0);
            more = 1'b0;
            for (int q = p + 1; q < NP; q++) if (live[q]) more = 1'b1;
            if (!more) break;
        end
        s = cyc;
        port_enable = '0;
        step();
        check("round_done_pulse", round_done, 1'b1);
        check("end_busy", busy, 1'b0);
        step();
        check("round_done_clear", round_done, 1'b0);
        exp_ov = 0;
        for (int c = t + 1; c <= s; c++) if (c % IVL == IVL - 1) exp_ov++;
        check("overrun_count", ov_cnt - ov0, exp_ov);
        check("round_done_count", rd_cnt - rd0, 1);
        check("handshake_count", hs_cnt - hs0, n_polls);
    endtask

    task automatic set_engine(input int k, input int r);
        for (int i = 0; i < NP; i++) begin
            ka[i] = k;
            ra[i] = r;
        end
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_valid", poll_valid, 1'b0);
        check("rst_port", poll_port, 2'd0);
        check("rst_ts", timeout_status, 4'd0);
        check("rst_round_done", round_done, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        cyc   = 0;

        // Two full rounds, ports 0,1,3 with done on the third WAIT cycle.
        set_engine(3, 0);
        run_round(4'b1011, -1, -1);
        run_round(4'b1011, -1, -1);

        // Timeout on port 0, then recovery.
        set_engine(0, 0);
        run_round(4'b0001, -1, -1);
        set_engine(5, 0);
        run_round(4'b0001, -1, -1);

        // Backpressure: ready held low for 10 cycles.
        set_engine(4, 10);
        run_round(4'b0100, -1, -1);

        // All ports time out; the round spans several ticks.
        set_engine(0, 0);
        run_round(4'b1111, -1, -1);

        // Done on the expiry cycle wins; done one cycle earlier.
        set_engine(TOUT, 0);
        ka[2] = TOUT - 1;
        run_round(4'b1100, -1, -1);

        // Port 2 disabled while port 1 waits; then an empty round.
        set_engine(2, 1);
        run_round(4'b0111, 1, 2);
        run_round(4'b0000, -1, -1);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NP; i++) begin
                ka[i] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TOUT));
                ra[i] = int'($urandom_range(0, 3));
            end
            run_round(4'($urandom_range(0, 15)), -1, -1);
        end

        // Leave a timeout flag set, then reset during a request.
        set_engine(0, 0);
        run_round(4'b0010, -1, -1);
        check("pre_reset_ts", timeout_status, exp_ts);
        port_enable = 4'b0011;
        wait_tick(t);
        step();
        step();
        check("pre_reset_req", poll_valid, 1'b1);
        poll_ready = 1'b0;
        reset = 1'b1;
        step();
        check("reset_valid", poll_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_ts", timeout_status, 4'd0);
        reset  = 1'b0;
        cyc    = 0;
        exp_ts = '0;
        set_engine(2, 0);
        run_round(4'b0001, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
